// File: rtl/interval_meter_if.sv
// Start/stop request and measurement result bundle for interval_meter.
interface interval_meter_if #(
   parameter int WIDTH = 10
);
   logic             start;
   logic             stop;
   logic [WIDTH-1:0] measured;
   logic             valid;
   logic             timed_out;
   logic             busy;

   // The requester drives start/stop and observes the result.
   modport master (
      output start,
      output stop,
      input  measured,
      input  valid,
      input  timed_out,
      input  busy
   );

   // The meter samples start/stop and produces the result.
   modport slave (
      input  start,
      input  stop,
      output measured,
      output valid,
      output timed_out,
      output busy
   );
endinterface

// File: rtl/interval_meter.sv
// Interval meter: counts whole prescaled ticks between a start event and a
// stop event and reports the count with a one-cycle valid pulse, or ends the
// measurement with a timeout flag when stop never arrives.
module interval_meter #(
   parameter int COUNT_GOAL    = 2024,
   parameter int WIDTH         = 10,
   parameter int TIMEOUT_TICKS = 1023
) (
   input  logic                   clk,
   input  logic                   reset,
   interval_meter_if.slave        bus
);

   localparam int PW = (COUNT_GOAL > 1) ? $clog2(COUNT_GOAL) : 1;
   localparam logic [PW-1:0]    PRESC_LAST  = PW'(COUNT_GOAL - 1);
   localparam logic [WIDTH-1:0] TIMEOUT_VAL = WIDTH'(TIMEOUT_TICKS);

   typedef enum logic {
      IDLE      = 1'b0,
      MEASURING = 1'b1
   } state_t;

   state_t           r_state;
   logic [PW-1:0]    r_presc;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_measured;
   logic             r_valid;
   logic             r_timedOut;
   logic             r_busy;

   logic             w_tick;
   logic [WIDTH-1:0] w_countNext;

   // A tick marks the last cycle of each prescaler period.
   assign w_tick      = (r_presc == PRESC_LAST);
   assign w_countNext = r_count + 1'b1;

   // Measurement FSM with prescaler, tick counter and registered outputs;
   // inside a measurement start outranks stop, which outranks the timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_presc    <= '0;
         r_count    <= '0;
         r_measured <= '0;
         r_valid    <= 1'b0;
         r_timedOut <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_state <= MEASURING;
                  r_presc <= '0;
                  r_count <= '0;
                  r_busy  <= 1'b1;
               end
            end
            MEASURING: begin
               if (bus.start) begin
                  r_presc <= '0;
                  r_count <= '0;
               end else if (bus.stop) begin
                  r_measured <= r_count;
                  r_timedOut <= 1'b0;
                  r_valid    <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= IDLE;
               end else if (w_tick) begin
                  r_presc <= '0;
                  if (w_countNext == TIMEOUT_VAL) begin
                     r_measured <= TIMEOUT_VAL;
                     r_timedOut <= 1'b1;
                     r_valid    <= 1'b1;
                     r_busy     <= 1'b0;
                     r_state    <= IDLE;
                  end else begin
                     r_count <= w_countNext;
                  end
               end else begin
                  r_presc <= r_presc + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.measured  = r_measured;
   assign bus.valid     = r_valid;
   assign bus.timed_out = r_timedOut;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_interval_meter.sv
// Testbench for interval_meter: directed scenarios followed by random
// start/stop/reset traffic, all compared against an arithmetic reference.
module tb_interval_meter;

   localparam int G     = 4;
   localparam int W     = 10;
   localparam int TMO   = 12;

   logic clk;
   logic reset;

   interval_meter_if #(.WIDTH(W)) imIf ();

   interval_meter #(
      .COUNT_GOAL   (G),
      .WIDTH        (W),
      .TIMEOUT_TICKS(TMO)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (imIf.slave)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vecCount  = 0;
   int missCount = 0;

   // Reference: cycle index of the current edge, start cycle of the running
   // measurement, and expected outputs derived from ticks = floor((t-s-1)/G).
   int cyc       = 0;
   int mStart    = 0;
   bit mActive   = 1'b0;
   int expMeas   = 0;
   bit expValid  = 1'b0;
   bit expTo     = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] required);
      vecCount++;
      assert (observed === required) else begin
         missCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)",
                tag, observed, required, cyc);
      end
   endtask

   // Drive one cycle of inputs, advance the reference and compare all outputs.
   task automatic applyStimulus(input bit st, input bit sp, input bit rs);
      imIf.start = st;
      imIf.stop  = sp;
      reset      = rs;
      @(posedge clk);
      expValid = 1'b0;
      if (rs) begin
         mActive = 1'b0;
         expMeas = 0;
         expTo   = 1'b0;
      end else if (st) begin
         mActive = 1'b1;
         mStart  = cyc;
      end else if (mActive && sp) begin
         expMeas  = (cyc - mStart - 1) / G;
         expTo    = 1'b0;
         expValid = 1'b1;
         mActive  = 1'b0;
      end else if (mActive && ((cyc - mStart) % G == 0) &&
                   ((cyc - mStart) / G == TMO)) begin
         expMeas  = TMO;
         expTo    = 1'b1;
         expValid = 1'b1;
         mActive  = 1'b0;
      end
      cyc++;
      #1;
      checkOutput("measured",  32'(imIf.measured),  32'(expMeas));
      checkOutput("valid",     32'(imIf.valid),     32'(expValid));
      checkOutput("timed_out", 32'(imIf.timed_out), 32'(expTo));
      checkOutput("busy",      32'(imIf.busy),      32'(mActive));
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      imIf.start = 1'b0;
      imIf.stop  = 1'b0;
      reset      = 1'b1;
      $display("[TB] interval_meter bench, G=%0d TIMEOUT_TICKS=%0d", G, TMO);

      // Reset state
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("rst_busy", 32'(imIf.busy), 32'd0);
      checkOutput("rst_meas", 32'(imIf.measured), 32'd0);

      // Stop 41 cycles after start -> 10 ticks
      applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(40);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("stop41_meas",  32'(imIf.measured), 32'd10);
      checkOutput("stop41_valid", 32'(imIf.valid), 32'd1);
      checkOutput("stop41_busy",  32'(imIf.busy), 32'd0);
      idleCycles(2);

      // Stop coincident with a tick -> tick discarded
      applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(39);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("stop40_meas", 32'(imIf.measured), 32'd9);

      // Stop before the first tick
      applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(2);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("stop3_meas",  32'(imIf.measured), 32'd0);
      checkOutput("stop3_valid", 32'(imIf.valid), 32'd1);
      idleCycles(2);

      // Timeout after TMO ticks, late stop ignored
      applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(48);
      checkOutput("tmo_meas",  32'(imIf.measured), 32'(TMO));
      checkOutput("tmo_flag",  32'(imIf.timed_out), 32'd1);
      checkOutput("tmo_valid", 32'(imIf.valid), 32'd1);
      idleCycles(5);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("late_stop_valid", 32'(imIf.valid), 32'd0);
      idleCycles(2);

      // Stop on the very tick that would time out -> stop wins
      applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(47);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("edge_meas", 32'(imIf.measured), 32'(TMO - 1));
      checkOutput("edge_flag", 32'(imIf.timed_out), 32'd0);
      idleCycles(2);

      // Restart mid-measurement, then start+stop together
      applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(9);
      applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(20);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("restart_meas", 32'(imIf.measured), 32'd5);
      applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(5);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("startstop_valid", 32'(imIf.valid), 32'd0);
      checkOutput("startstop_busy",  32'(imIf.busy), 32'd1);
      idleCycles(6);
      applyStimulus(1'b0, 1'b1, 1'b0);
      idleCycles(2);

      // Reset mid-measurement aborts without a result
      applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(14);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("abort_busy", 32'(imIf.busy), 32'd0);
      idleCycles(9);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("abort_valid", 32'(imIf.valid), 32'd0);
      checkOutput("abort_meas",  32'(imIf.measured), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(12);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("post_abort_meas", 32'(imIf.measured), 32'd3);

      // Idle stops, then start in the valid cycle
      idleCycles(1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("idle_stop_valid", 32'(imIf.valid), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(8);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("b2b_first", 32'(imIf.measured), 32'd2);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("b2b_busy", 32'(imIf.busy), 32'd1);
      idleCycles(20);
      checkOutput("b2b_hold", 32'(imIf.measured), 32'd2);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("b2b_second", 32'(imIf.measured), 32'd5);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(0, 39) == 0,
                       $urandom_range(0, 59) == 0,
                       $urandom_range(0, 499) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
